// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Purpose:
//   Parses the byte stream from a UART receiver into register-write commands.
//   A frame is HEADER, address, data, checksum, where the checksum is
//   (address + data) truncated to 8 bits. A good frame produces a one-cycle
//   wr_en pulse. A checksum mismatch or an inter-byte timeout inside a frame
//   produces a one-cycle frame_err pulse, and err_code records the cause.
//
// Handshake:
//   rx_data is valid only in a cycle where po_flag=1. There is no ready
//   signal: every po_flag cycle is consumed on the rising edge that samples it.
//
// Ports:
//   sclk       in   1  system clock, rising edge
//   s_rst_n    in   1  asynchronous active-low reset
//   rx_data    in   8  received byte, qualified by po_flag
//   po_flag    in   1  one-cycle byte-valid strobe
//   wr_en      out  1  one-cycle pulse, frame passed its checksum
//   wr_addr    out  8  address of the last good frame (held)
//   wr_data    out  8  data of the last good frame (held)
//   frame_err  out  1  one-cycle pulse, checksum fail or timeout
//   err_code   out  2  last error cause: 01 checksum, 10 timeout (held)
//   ok_cnt     out  8  good-frame count, wraps 255 -> 0
//   dbg_state  out  2  current parser state (IDLE=0, ADDR=1, DATA=2, CSUM=3)
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter logic [15:0] TIMEOUT_END = 16'd8679
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] ok_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [7:0]  addr_q,      addr_d;
    logic [7:0]  data_q,      data_d;
    logic        wr_en_q,     wr_en_d;
    logic [7:0]  wr_addr_q,   wr_addr_d;
    logic [7:0]  wr_data_q,   wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q,  err_code_d;
    logic [7:0]  ok_cnt_q,    ok_cnt_d;

    logic [7:0]  csum_exp;
    logic        timeout_hit;

    // Modulo-256 sum of the latched address and data bytes.
    assign csum_exp = addr_q + data_q;

    // A byte in the same cycle as the terminal count wins over the timeout.
    assign timeout_hit = (state_q != IDLE) && !po_flag && (cnt_q == TIMEOUT_END);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            addr_q      <= 8'd0;
            data_q      <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
            ok_cnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            ok_cnt_q    <= ok_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        ok_cnt_d    = ok_cnt_q;

        // Inter-byte idle counter: only runs while a frame is in progress.
        if (state_q == IDLE) begin
            cnt_d = 16'd0;
        end else if (po_flag) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (timeout_hit) begin
            state_d     = IDLE;
            cnt_d       = 16'd0;
            addr_d      = 8'd0;
            data_d      = 8'd0;
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
        end else if (po_flag) begin
            case (state_q)
                IDLE: begin
                    // Non-header bytes between frames are dropped silently.
                    if (rx_data == HEADER) begin
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    addr_d  = rx_data;
                    state_d = DATA;
                end
                DATA: begin
                    data_d  = rx_data;
                    state_d = CSUM;
                end
                CSUM: begin
                    state_d = IDLE;
                    if (rx_data == csum_exp) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_q;
                        ok_cnt_d  = ok_cnt_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b01;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign ok_cnt    = ok_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame controller that sits directly behind the UART receiver and turns its byte stream (`rx_data` qualified by the one-cycle `po_flag` strobe) into register-write commands. It hunts for a header byte, collects an address byte and a data byte, and checks a modulo-256 checksum. Complete frames become a single-cycle write strobe; bad or stalled frames become an error strobe. An inter-byte timeout resynchronises the parser if the line goes quiet mid-frame.

## Interface
- `HEADER`, 8'hAA: frame start byte.
- `TIMEOUT_END`, 16'd8679: idle cycles allowed between bytes inside a frame, minus 1. This is about 2 byte times at 50 MHz / 115200.
- `sclk`  in  1  system clock; all logic on rising edge.
- `s_rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only in a cycle where `po_flag`=1.
- `po_flag`  in  1  one-cycle byte-valid strobe from the receiver.
- `wr_en`  out  1  one-cycle pulse; a frame passed its checksum.
- `wr_addr`  out  8  address of the last good frame; held between frames.
- `wr_data`  out  8  data of the last good frame; held between frames.
- `frame_err`  out  1  one-cycle pulse on checksum fail or timeout.
- `err_code`  out  2  cause of the last error: 2'b01 checksum, 2'b10 timeout. Held until the next error.
- `ok_cnt`  out  8  count of good frames; wraps 255 -> 0.

## Operation
- Reset values: state IDLE; `wr_en`=0, `frame_err`=0, `err_code`=0, `wr_addr`=0, `wr_data`=0, `ok_cnt`=0; timeout counter=0; internal addr/data latches=0.
- States and transitions; every transition below happens only in a cycle with `po_flag`=1:
  - IDLE: `rx_data`==HEADER -> ADDR. Any other byte is dropped silently, with no error.
  - ADDR: latch `rx_data` as addr -> DATA.
  - DATA: latch `rx_data` as data -> CSUM.
  - CSUM: compare `rx_data` with (addr + data)[7:0], i.e. the 9-bit sum truncated to 8 bits. Either outcome -> IDLE.
    - Match: `wr_en`=1, `wr_addr`/`wr_data` load the latched values, `ok_cnt`+1.
    - Mismatch: `frame_err`=1, `err_code`=2'b01. Outputs otherwise unchanged.
- No resync inside a frame: a HEADER value received in ADDR, DATA or CSUM is treated as an ordinary payload/checksum byte.
- Timeout counter, 16 bits:
  - Held at 0 in IDLE.
  - In ADDR/DATA/CSUM: cleared to 0 on a `po_flag` cycle, otherwise +1.
  - A sampled value of TIMEOUT_END with `po_flag`=0 gives: state -> IDLE, counter -> 0, `frame_err`=1, `err_code`=2'b10. Latched addr/data are discarded.
- Simultaneous events:
  - `po_flag`=1 in the same cycle the counter equals TIMEOUT_END: the byte wins; it is processed normally and no timeout occurs.
  - `wr_en` and `frame_err` are never high in the same cycle.
- Reset mid-frame: immediate return to IDLE. The partial frame is lost and no error is flagged.

## Timing
- All outputs are registered. `wr_en`/`frame_err` rise on the edge that samples the checksum byte's `po_flag`, so they are visible 1 cycle after the `po_flag` cycle. Each is high for exactly 1 cycle.
- `wr_addr`, `wr_data`, `ok_cnt` and `err_code` update on the same edge as their strobe.
- Timeout fires TIMEOUT_END+1 rising edges after the last accepted byte's `po_flag` edge.
- Back-to-back frames: a HEADER arriving on the `po_flag` cycle right after the CSUM byte is accepted, because the state is already IDLE. There is no dead cycle.
- No backpressure; every `po_flag` is consumed in its own cycle.

## Test plan
- Bytes AA,12,34,46 -> one `wr_en` pulse with `wr_addr`=0x12, `wr_data`=0x34; `ok_cnt`=1; `frame_err` stays 0.
- Bytes AA,12,34,47 -> `frame_err` pulse, `err_code`=01; `wr_en` stays 0; `wr_addr`/`wr_data` unchanged; `ok_cnt` unchanged.
- Bytes 00,FF,AA,FF,02,01 (sum 0x101 truncates to 0x01) -> leading 00/FF ignored; `wr_en` with addr 0xFF, data 0x02.
- Bytes AA,12 then silence, with TIMEOUT_END=15 -> `frame_err` with `err_code`=10 exactly 16 edges after the 0x12 edge. A following frame AA,01,02,03 then writes addr 0x01, data 0x02.
- Byte arriving exactly when counter==TIMEOUT_END -> no timeout, and the frame completes normally.
- Reset assertion after AA,12 -> all outputs return to their reset values. A following AA,05,06,0B writes addr 0x05, data 0x06, `ok_cnt`=1. Separately, 256 good frames -> `ok_cnt` wraps to 0.
